// File: rtl/pipelined_multiplier_pkg.sv
// Shared types for the RV32M multiply functional unit: operation encoding
// and the operand-extension / result-select rules that go with it.
package pipelined_multiplier_pkg;

    typedef enum logic [1:0] {
        MUL_MUL    = 2'b00,
        MUL_MULH   = 2'b01,
        MUL_MULHSU = 2'b10,
        MUL_MULHU  = 2'b11
    } mul_func_e;

    // rs1 is treated as signed for MULH and MULHSU.
    function automatic logic opa_is_signed(input mul_func_e f);
        return (f == MUL_MULH) || (f == MUL_MULHSU);
    endfunction

    function automatic logic opb_is_signed(input mul_func_e f);
        return (f == MUL_MULH);
    endfunction

    // Only MUL returns the low half of the product.
    function automatic logic want_high_half(input mul_func_e f);
        return (f != MUL_MUL);
    endfunction

endpackage

// File: rtl/pipelined_multiplier_stage.sv
// One combinational slice of the multiplier: adds opa_ext times a C-bit chunk
// of opb, shifted into place, and applies the opb sign correction in the last slice.
module mult_stage #(
    parameter int XLEN  = 32,
    parameter int C     = 8,
    parameter int SHIFT = 0,
    parameter bit LAST  = 1'b0
) (
    input  logic [XLEN:0]       opa_ext,
    input  logic [C:0]          opb_bits,
    input  logic [2*XLEN+1:0]   acc_in,
    output logic [2*XLEN+1:0]   acc_out
);

    localparam int ACC_W = 2 * XLEN + 2;

    logic [ACC_W-1:0] opa_wide;
    logic [ACC_W-1:0] chunk_wide;
    logic [ACC_W-1:0] partial;
    logic [ACC_W-1:0] correction;
    logic             sub_en;

    always_comb begin
        opa_wide   = {{(XLEN + 1){opa_ext[XLEN]}}, opa_ext};
        chunk_wide = ACC_W'(opb_bits[C-1:0]);
        partial    = (opa_wide * chunk_wide) << SHIFT;
        // opb_bits[C] is the opb_ext sign bit only once every lower chunk is consumed.
        sub_en     = LAST && opb_bits[C];
        correction = sub_en ? (opa_wide << XLEN) : '0;
        acc_out    = acc_in + partial - correction;
    end

endmodule

// File: rtl/pipelined_multiplier.sv
// Pipelined RV32M multiply unit for the execute stage: STAGES-deep partial-product
// pipe carrying the destination tag, with global stall on CDB backpressure and flush.
module pipelined_multiplier
    import pipelined_multiplier_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  opa,
    input  logic [XLEN-1:0]  opb,
    input  mul_func_e        func,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int C     = XLEN / STAGES;
    localparam int ACC_W = 2 * XLEN + 2;

    if (STAGES < 1 || STAGES > XLEN || (XLEN % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_multiplier: STAGES must be in 1..XLEN and divide XLEN");
    end

    typedef struct packed {
        logic             valid;
        mul_func_e        func;
        logic [TAG_W-1:0] tag;
        logic [XLEN:0]    opa_ext;
        logic [XLEN:0]    opb_rem;
        logic [ACC_W-1:0] acc;
    } stage_t;

    stage_t           stage_q   [STAGES];
    stage_t           stage_in  [STAGES];
    stage_t           stage_d   [STAGES];
    logic [ACC_W-1:0] stage_acc [STAGES];
    stage_t           tail;
    logic [XLEN:0]    opa_ext_w;
    logic [XLEN:0]    opb_ext_w;
    logic             stall;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; ready never depends on the same side's valid, and an offered op with
    // valid high stays put until it transfers. in_ready falls only while the tail
    // op is waiting for its CDB grant, which freezes the whole pipe.
    assign tail      = stage_q[STAGES-1];
    assign out_valid = tail.valid;
    assign out_tag   = tail.tag;
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    always_comb begin
        opa_ext_w = {opa_is_signed(func) ? opa[XLEN-1] : 1'b0, opa};
        opb_ext_w = {opb_is_signed(func) ? opb[XLEN-1] : 1'b0, opb};
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stage_in[i] = '{
                valid:   in_valid,
                func:    func,
                tag:     in_tag,
                opa_ext: opa_ext_w,
                opb_rem: opb_ext_w,
                acc:     '0
            };
        end else begin : g_body
            assign stage_in[i] = stage_q[i-1];
        end

        mult_stage #(
            .XLEN  (XLEN),
            .C     (C),
            .SHIFT (i * C),
            .LAST  (i == STAGES - 1)
        ) u_mult_stage (
            .opa_ext  (stage_in[i].opa_ext),
            .opb_bits (stage_in[i].opb_rem[C:0]),
            .acc_in   (stage_in[i].acc),
            .acc_out  (stage_acc[i])
        );

        // The consumed chunk is shifted out so the next slice always reads bits [C:0].
        assign stage_d[i] = '{
            valid:   stage_in[i].valid,
            func:    stage_in[i].func,
            tag:     stage_in[i].tag,
            opa_ext: stage_in[i].opa_ext,
            opb_rem: stage_in[i].opb_rem >> C,
            acc:     stage_acc[i]
        };
    end

    // Reset beats flush, flush beats stall; payloads of flushed slots are don't-care.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i].valid <= 1'b0;
            end
        end else if (!stall) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        out_result = tail.acc[XLEN-1:0];
        if (want_high_half(tail.func)) begin
            out_result = tail.acc[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Directed plus randomized bench for pipelined_multiplier, checked against a
// plain 64-bit arithmetic reference and an expected-result queue.
module tb_pipelined_multiplier;
    import pipelined_multiplier_pkg::*;

    localparam int XLEN   = 32;
    localparam int STAGES = 4;
    localparam int TAG_W  = 5;
    localparam int W      = TAG_W + XLEN;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [XLEN-1:0]  opa = '0;
    logic [XLEN-1:0]  opb = '0;
    mul_func_e        func = MUL_MUL;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           rand_bp  = 1'b0;

    pipelined_multiplier #(
        .XLEN   (XLEN),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opa        (opa),
        .opb        (opb),
        .func       (func),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: the product of the extended operands, computed in 64-bit arithmetic
    function automatic logic [XLEN-1:0] ref_model(input mul_func_e f, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            MUL_MULH:   p = sa * sb;
            MUL_MULHSU: p = sa * longint'(ub);
            default:    p = ua * ub;
        endcase
        return (f == MUL_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [XLEN-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every retiring op must match the head of the expected queue
    always @(negedge clock) begin : monitor
        logic [W-1:0] e;
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sb_tag", out_tag, e[W-1:XLEN]);
                check("sb_result", out_result, e[XLEN-1:0]);
            end
        end
    end

    always @(posedge clock) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input mul_func_e f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] t);
        int waited = 0;
        in_valid = 1'b1;
        func     = f;
        opa      = a;
        opb      = b;
        in_tag   = t;
        @(negedge clock);
        while (!in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            check("issue_timeout", in_ready, 1'b1);
        end else begin
            @(posedge clock);
            exp_q.push_back({t, ref_model(f, a, b)});
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_one(input string name, input mul_func_e f, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t,
                           input logic [XLEN-1:0] exp_res);
        issue(f, a, b, t);
        for (int j = 0; j < STAGES; j++) begin
            @(negedge clock);
            check({name, "_valid_latency"}, out_valid, (j == STAGES - 1));
        end
        check({name, "_tag"}, out_tag, t);
        check({name, "_result"}, out_result, exp_res);
        step();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        repeat (STAGES + 2) step();
    endtask

    // Stimulus
    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_result", out_result, 0);
        check("reset_out_tag", out_tag, 0);
        check("reset_in_ready", in_ready, 1'b1);
        step();

        run_one("mul_basic", MUL_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB);
        run_one("mulh_min", MUL_MULH, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000);
        run_one("mulhu_max", MUL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
        run_one("mulhsu_m1", MUL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF);
        wait_drain("directed");

        // Back-to-back stream of four ops
        for (int t = 1; t <= 4; t++) begin
            issue(MUL_MUL, $urandom, $urandom, 5'(t));
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            check("stream_valid", out_valid, 1'b1);
            check("stream_tag", out_tag, 5'(j + 1));
        end
        @(negedge clock);
        check("stream_end_valid", out_valid, 1'b0);
        wait_drain("stream");

        // Fill the pipe, then withhold the grant for three cycles
        for (int t = 5; t <= 8; t++) begin
            issue(mul_func_e'($urandom_range(0, 3)), pick_operand(), pick_operand(), 5'(t));
        end
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_tag", out_tag, exp_q[0][W-1:XLEN]);
            check("stall_result", out_result, exp_q[0][XLEN-1:0]);
            if (j < 2) step();
        end
        out_ready = 1'b1;
        wait_drain("backpressure");

        // Flush with three ops in flight and a fourth offered alongside
        for (int t = 11; t <= 13; t++) begin
            issue(MUL_MULHU, $urandom, $urandom, 5'(t));
        end
        in_valid = 1'b1;
        func     = MUL_MUL;
        opa      = 32'd3;
        opb      = 32'd3;
        in_tag   = 5'd14;
        flush    = 1'b1;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        run_one("after_flush", MUL_MUL, 32'd6, 32'd7, 5'd9, 32'd42);
        wait_drain("flush");

        // Random ops, random gaps and random CDB backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) step();
            issue(mul_func_e'($urandom_range(0, 3)), pick_operand(), pick_operand(), 5'(n));
        end
        rand_bp = 1'b0;
        @(posedge clock);
        #2;
        out_ready = 1'b1;
        wait_drain("random");

        // Reset in the middle of a stream
        for (int t = 20; t <= 22; t++) begin
            issue(MUL_MULH, $urandom, $urandom, 5'(t));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_out_result", out_result, 0);
        check("midreset_out_tag", out_tag, 0);
        step();
        @(negedge clock);
        check("midreset_in_ready", in_ready, 1'b1);
        check("midreset_still_idle", out_valid, 1'b0);
        step();
        run_one("after_reset", MUL_MULH, 32'hFFFF_FFFE, 32'h0000_0003, 5'd17, 32'hFFFF_FFFF);
        wait_drain("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
